sequenciador_notas: RTL and testbench
=====================================

Name: sequenciador_notas

Overview:
Parametrised note recorder/player for the FPGAudio piano: records live key events as {note, duration-in-ticks} entries, including rests, into an internal synchronous RAM, and plays them back against an external tick, once or looped. It is the next generation of the fixed 256x4 note/tempo memory path, generalised in depth, note width and duration width. It adds rest capture, duration saturation, overflow detection and loop playback. It sits between the key encoder/metronome and the buzzer/LED decoder.

Parameters:
NUM_NOTAS, 256, entry depth (power of 2, >=2)
NOTA_W, 4, encoded note width
TEMPO_W, 4, duration width in ticks; max duration DMAX = 2^TEMPO_W-1
NOTA_PAUSA, {NOTA_W{1'b1}}, note code reserved for rest entries

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-cycle time-base pulse from the metronome; spacing >=3 cycles
nota_in  in  NOTA_W  encoded live note
nota_ativa  in  1  level, a key is held
grava_inicia  in  1  pulse, start recording
toca_inicia  in  1  pulse, start playback
para  in  1  pulse, stop recording or playback
loop  in  1  level, sampled at toca_inicia
nota_out  out  NOTA_W  played note
nota_out_valida  out  1  nota_out is a real note, not a rest
gravando  out  1  in a recording state
tocando  out  1  in a playback state
cheio  out  1  memory overflowed during the last recording
fim_reproducao  out  1  one-cycle pulse at the natural end of non-loop playback
comprimento  out  $clog2(NUM_NOTAS)+1  number of valid entries
db_estado  out  3  state code for debug

Behaviour:
- Reset: state OCIOSO. All outputs 0 (nota_out 0, comprimento 0, cheio 0). RAM contents are not cleared. Reset overrides every other input, including mid-operation.
- States: OCIOSO, GRAVA_ESPERA, GRAVA_NOTA, GRAVA_PAUSA, TOCA_LE, TOCA_CARREGA, TOCA_NOTA.
- Command priority: para > grava_inicia > toca_inicia. inicia pulses are honoured only in OCIOSO. para in any state goes to OCIOSO next cycle.
- grava_inicia: clear comprimento, cheio and write address, then go to GRAVA_ESPERA. Leading silence is never stored.
- GRAVA_ESPERA: on nota_ativa, latch nota_in, clear the duration counter dc, go to GRAVA_NOTA.
- GRAVA_NOTA:
  - Each tick increments dc, saturating at DMAX. Holding longer never splits the entry.
  - On release, or on nota_in change while held: write {note, max(dc,1)} at the address and increment comprimento.
  - After a release, go to GRAVA_PAUSA with dc=0. After a change, latch the new note and stay with dc=0.
  - para here writes the pending note entry first, then goes to OCIOSO.
- GRAVA_PAUSA:
  - Ticks count dc (saturating).
  - On nota_ativa: if dc>=1, write {NOTA_PAUSA, dc} and then start the note. If dc=0, start the note without a rest entry.
  - para here discards the trailing rest.
- Full: a write to address NUM_NOTAS-1 sets cheio=1 and goes to OCIOSO in the same cycle (auto-stop). Further key activity is ignored.
- toca_inicia:
  - If comprimento=0, pulse fim_reproducao next cycle and stay in OCIOSO.
  - Otherwise latch loop, set address 0, go to TOCA_LE.
- TOCA_LE: drive the RAM address. The RAM has 1-cycle read latency. Go to TOCA_CARREGA.
- TOCA_CARREGA:
  - Load the down-counter with the stored duration.
  - Update nota_out; nota_out_valida = (note != NOTA_PAUSA).
  - Go to TOCA_NOTA. nota_out holds its previous value through LE/CARREGA, so there is no glitch.
- TOCA_NOTA:
  - Each tick decrements the counter. An entry lasts exactly its stored duration in ticks.
  - On the tick where the counter is 1: if address+1 < comprimento, increment the address and go to TOCA_LE.
  - Otherwise, if loop is set, set address 0 and go to TOCA_LE.
  - Otherwise go to OCIOSO, clear nota_out_valida and pulse fim_reproducao.
  - Ticks arriving during TOCA_LE/TOCA_CARREGA are ignored; the spacing constraint guarantees none are lost.
- para during playback: OCIOSO next cycle, nota_out_valida=0, no fim_reproducao pulse.
- gravando = state in {GRAVA_*}; tocando = state in {TOCA_*}.

Decomposition:
- Shared package sequenciador_pkg: state encoding (3-bit localparams), the default NOTA_PAUSA, and the entry-width helper NOTA_W+TEMPO_W.
- One sub-module, ram_sequencia_nxw: a single-port synchronous RAM, NUM_NOTAS x (NOTA_W+TEMPO_W), with registered read and write-enable.

Test Plan:
All scenarios use NUM_NOTAS=8, NOTA_W=4, TEMPO_W=4, tick every 10 cycles.
1. Record: grava_inicia; hold note 3 for 2 ticks; release for 1 tick; hold note 5 for 3 ticks; para -> comprimento=3, entries {3,2},{F,1},{5,3}.
2. Play scenario 1 with loop=0 -> nota_out 3 valid for 20 cycles, rest (valida=0) for 10, note 5 for 30, then fim_reproducao single pulse and tocando=0.
3. Press and release note 7 within 4 cycles (no tick), then para -> entry {7,1}. Hold note 2 for 20 ticks -> entry {2,15} (saturated, no split).
4. Overflow: record 9 alternating note/rest events -> cheio=1 after the 8th write, comprimento=8, gravando=0, 9th event ignored.
5. Loop: play with loop=1 for 2 passes -> address wraps 2->0 without fim_reproducao. para -> OCIOSO next cycle, nota_out_valida=0.
6. Reset asserted mid-playback -> all outputs 0 next cycle. A subsequent toca_inicia with comprimento=0 -> fim_reproducao pulse and no state change.

Source files
------------

// File: rtl/sequenciador_pkg.sv
// Shared definitions for the note sequencer: state codes, rest code default
// and the RAM entry width helper.
package sequenciador_pkg;

  localparam logic [2:0] EST_OCIOSO       = 3'd0;
  localparam logic [2:0] EST_GRAVA_ESPERA = 3'd1;
  localparam logic [2:0] EST_GRAVA_NOTA   = 3'd2;
  localparam logic [2:0] EST_GRAVA_PAUSA  = 3'd3;
  localparam logic [2:0] EST_TOCA_LE      = 3'd4;
  localparam logic [2:0] EST_TOCA_CARREGA = 3'd5;
  localparam logic [2:0] EST_TOCA_NOTA    = 3'd6;

  typedef enum logic [2:0] {
    OCIOSO       = EST_OCIOSO,
    GRAVA_ESPERA = EST_GRAVA_ESPERA,
    GRAVA_NOTA   = EST_GRAVA_NOTA,
    GRAVA_PAUSA  = EST_GRAVA_PAUSA,
    TOCA_LE      = EST_TOCA_LE,
    TOCA_CARREGA = EST_TOCA_CARREGA,
    TOCA_NOTA    = EST_TOCA_NOTA
  } estado_t;

  // Rest code is all-ones; the top slices this to its note width.
  localparam logic [31:0] PAUSA_UNS = '1;

  function automatic int largura_entrada(input int nota_w, input int tempo_w);
    return nota_w + tempo_w;
  endfunction

endpackage

// File: rtl/ram_sequencia_nxw.sv
// Single-port synchronous RAM holding {note, duration} entries; read data is
// registered, so it is valid one cycle after the address is presented.
module ram_sequencia_nxw #(
  parameter int PROF = 256,
  parameter int LARG = 8
) (
  input  logic                    clock,
  input  logic                    we_i,
  input  logic [$clog2(PROF)-1:0] addr_i,
  input  logic [LARG-1:0]         wdata_i,
  output logic [LARG-1:0]         rdata_o
);

  logic [LARG-1:0] mem_q [PROF];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/sequenciador_notas.sv
// Note recorder/player: captures {note, ticks} entries (rests included) from
// live key events and replays them against the metronome tick, once or looped.
module sequenciador_notas
  import sequenciador_pkg::*;
#(
  parameter int                NUM_NOTAS  = 256,
  parameter int                NOTA_W     = 4,
  parameter int                TEMPO_W    = 4,
  parameter logic [NOTA_W-1:0] NOTA_PAUSA = PAUSA_UNS[NOTA_W-1:0]
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tick,
  input  logic [NOTA_W-1:0]           nota_in,
  input  logic                        nota_ativa,
  input  logic                        grava_inicia,
  input  logic                        toca_inicia,
  input  logic                        para,
  input  logic                        loop,
  output logic [NOTA_W-1:0]           nota_out,
  output logic                        nota_out_valida,
  output logic                        gravando,
  output logic                        tocando,
  output logic                        cheio,
  output logic                        fim_reproducao,
  output logic [$clog2(NUM_NOTAS):0]  comprimento,
  output logic [2:0]                  db_estado
);

  localparam int                 AW   = $clog2(NUM_NOTAS);
  localparam int                 EW   = largura_entrada(NOTA_W, TEMPO_W);
  localparam logic [TEMPO_W-1:0] DMAX = '1;

  estado_t             estado_q;
  logic [AW-1:0]       addr_q;
  logic [AW:0]         comp_q;
  logic                cheio_q, loop_q, valida_q, fim_q;
  logic [NOTA_W-1:0]   nota_q, nota_out_q;
  logic [TEMPO_W-1:0]  dc_q, cnt_q;

  logic                fecha_nota, fecha_pausa, ram_we, ultimo, tem_prox;
  logic [EW-1:0]       ram_wdata, ram_rdata;
  logic [TEMPO_W-1:0]  dc_d;
  logic [AW-1:0]       addr_d;
  logic [NOTA_W-1:0]   rd_nota;
  logic [TEMPO_W-1:0]  rd_tempo;

  ram_sequencia_nxw #(.PROF(NUM_NOTAS), .LARG(EW)) u_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .addr_i  (addr_q),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign rd_nota  = ram_rdata[EW-1:TEMPO_W];
  assign rd_tempo = ram_rdata[TEMPO_W-1:0];

  always_comb begin
    dc_d        = (dc_q == DMAX) ? dc_q : dc_q + TEMPO_W'(1);
    addr_d      = addr_q + AW'(1);
    ultimo      = (addr_q == AW'(NUM_NOTAS - 1));
    tem_prox    = ({1'b0, addr_q} + (AW+1)'(1)) < comp_q;
    // A held note is closed by release, a note change or a stop command.
    fecha_nota  = (estado_q == GRAVA_NOTA) && (para || !nota_ativa || (nota_in != nota_q));
    fecha_pausa = (estado_q == GRAVA_PAUSA) && !para && nota_ativa && (dc_q != '0);
    ram_we      = fecha_nota || fecha_pausa;
    ram_wdata   = fecha_nota ? {nota_q, (dc_q == '0) ? TEMPO_W'(1) : dc_q}
                             : {NOTA_PAUSA, dc_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      addr_q     <= '0;
      comp_q     <= '0;
      cheio_q    <= 1'b0;
      loop_q     <= 1'b0;
      valida_q   <= 1'b0;
      fim_q      <= 1'b0;
      nota_q     <= '0;
      nota_out_q <= '0;
      dc_q       <= '0;
      cnt_q      <= '0;
    end else begin
      fim_q <= 1'b0;
      if (ram_we) begin
        addr_q <= addr_d;
        comp_q <= comp_q + (AW+1)'(1);
        if (ultimo) cheio_q <= 1'b1;
      end
      case (estado_q)
        OCIOSO: begin
          if (para) begin
            estado_q <= OCIOSO;
          end else if (grava_inicia) begin
            comp_q   <= '0;
            cheio_q  <= 1'b0;
            addr_q   <= '0;
            estado_q <= GRAVA_ESPERA;
          end else if (toca_inicia) begin
            if (comp_q == '0) begin
              fim_q <= 1'b1;
            end else begin
              loop_q   <= loop;
              addr_q   <= '0;
              estado_q <= TOCA_LE;
            end
          end
        end
        GRAVA_ESPERA: begin
          if (para) begin
            estado_q <= OCIOSO;
          end else if (nota_ativa) begin
            nota_q   <= nota_in;
            dc_q     <= '0;
            estado_q <= GRAVA_NOTA;
          end
        end
        GRAVA_NOTA: begin
          if (fecha_nota && (para || ultimo)) begin
            estado_q <= OCIOSO;
          end else if (!nota_ativa) begin
            dc_q     <= '0;
            estado_q <= GRAVA_PAUSA;
          end else if (nota_in != nota_q) begin
            nota_q <= nota_in;
            dc_q   <= '0;
          end else if (tick) begin
            dc_q <= dc_d;
          end
        end
        GRAVA_PAUSA: begin
          if (para) begin
            estado_q <= OCIOSO;
          end else if (nota_ativa) begin
            if (fecha_pausa && ultimo) begin
              estado_q <= OCIOSO;
            end else begin
              nota_q   <= nota_in;
              dc_q     <= '0;
              estado_q <= GRAVA_NOTA;
            end
          end else if (tick) begin
            dc_q <= dc_d;
          end
        end
        TOCA_LE: begin
          if (para) begin
            valida_q <= 1'b0;
            estado_q <= OCIOSO;
          end else begin
            estado_q <= TOCA_CARREGA;
          end
        end
        TOCA_CARREGA: begin
          if (para) begin
            valida_q <= 1'b0;
            estado_q <= OCIOSO;
          end else begin
            cnt_q      <= rd_tempo;
            nota_out_q <= rd_nota;
            valida_q   <= (rd_nota != NOTA_PAUSA);
            estado_q   <= TOCA_NOTA;
          end
        end
        TOCA_NOTA: begin
          if (para) begin
            valida_q <= 1'b0;
            estado_q <= OCIOSO;
          end else if (tick) begin
            if (cnt_q <= TEMPO_W'(1)) begin
              if (tem_prox) begin
                addr_q   <= addr_d;
                estado_q <= TOCA_LE;
              end else if (loop_q) begin
                addr_q   <= '0;
                estado_q <= TOCA_LE;
              end else begin
                valida_q <= 1'b0;
                fim_q    <= 1'b1;
                estado_q <= OCIOSO;
              end
            end else begin
              cnt_q <= cnt_q - TEMPO_W'(1);
            end
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign nota_out        = nota_out_q;
  assign nota_out_valida = valida_q;
  assign cheio           = cheio_q;
  assign fim_reproducao  = fim_q;
  assign comprimento     = comp_q;
  assign db_estado       = estado_q;
  assign gravando        = (estado_q == GRAVA_ESPERA) || (estado_q == GRAVA_NOTA) ||
                           (estado_q == GRAVA_PAUSA);
  assign tocando         = (estado_q == TOCA_LE) || (estado_q == TOCA_CARREGA) ||
                           (estado_q == TOCA_NOTA);

endmodule

// File: tb/tb_sequenciador_notas.sv
// Directed + randomized bench: key events are driven tick-aligned and the
// expected entry list and playback sequence come from an event-level model.
module tb_sequenciador_notas;

  localparam int         N     = 8;
  localparam logic [3:0] PAUSA = 4'hF;

  logic       clock = 1'b0, reset = 1'b1, tick = 1'b0;
  logic [3:0] nota_in = '0;
  logic       nota_ativa = 0, grava_inicia = 0, toca_inicia = 0, para = 0, loop = 0;
  logic [3:0] nota_out;
  logic       nota_out_valida, gravando, tocando, cheio, fim_reproducao;
  logic [3:0] comprimento;
  logic [2:0] db_estado;

  int n_tests = 0, n_fail = 0;

  typedef struct { int nota; int dur; } ent_t;
  ent_t m_ent[$];
  bit   m_cheio;
  int   ev_n[8], ev_h[8], ev_g[8];

  sequenciador_notas #(.NUM_NOTAS(N), .NOTA_W(4), .TEMPO_W(4)) dut (
    .clock(clock), .reset(reset), .tick(tick), .nota_in(nota_in),
    .nota_ativa(nota_ativa), .grava_inicia(grava_inicia), .toca_inicia(toca_inicia),
    .para(para), .loop(loop), .nota_out(nota_out), .nota_out_valida(nota_out_valida),
    .gravando(gravando), .tocando(tocando), .cheio(cheio),
    .fim_reproducao(fim_reproducao), .comprimento(comprimento), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Metronome: one-cycle tick every 10 cycles.
  initial begin
    forever begin
      repeat (9) @(negedge clock);
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c;
    for (int k = 0; k < n; k++) begin
      c = 0;
      do begin @(posedge clock); c++; end while (!tick && c < 40);
      if (!tick) chk("tick_timeout", 0, 1);
    end
  endtask

  function automatic void m_add(input int nota, input int dur);
    ent_t e;
    if (m_cheio) return;
    e.nota = nota;
    e.dur  = (dur > 15) ? 15 : (dur < 1) ? 1 : dur;
    m_ent.push_back(e);
    if (m_ent.size() == N) m_cheio = 1;
  endfunction

  task automatic inicia_grava();
    wait_ticks(1);
    @(negedge clock); grava_inicia = 1;
    @(negedge clock); grava_inicia = 0;
    m_ent.delete(); m_cheio = 0;
    chk("gravando_ini", gravando, 1);
    chk("comp_ini", comprimento, 0);
    chk("cheio_ini", cheio, 0);
  endtask

  task automatic chk_grav(input string tag);
    chk({tag, "_comp"}, comprimento, m_ent.size());
    chk({tag, "_cheio"}, cheio, m_cheio);
  endtask

  // ev_g: rest ticks after release, or -1 for a note change while held.
  task automatic grava_seq(input int nev, input int fim_modo);
    inicia_grava();
    for (int i = 0; i < nev; i++) begin
      @(negedge clock); nota_in = ev_n[i]; nota_ativa = 1;
      if (i > 0 && ev_g[i-1] < 0) m_add(ev_n[i-1], ev_h[i-1]);
      if (i > 0 && ev_g[i-1] > 0) m_add(PAUSA, ev_g[i-1]);
      @(negedge clock);
      chk_grav("press");
      chk("press_gravando", gravando, !m_cheio);
      wait_ticks(ev_h[i]);
      if (i == nev - 1) begin
        if (fim_modo == 0) begin
          @(negedge clock); para = 1; m_add(ev_n[i], ev_h[i]);
          @(negedge clock); para = 0; nota_ativa = 0;
        end else begin
          @(negedge clock); nota_ativa = 0; m_add(ev_n[i], ev_h[i]);
          @(negedge clock); chk_grav("release_last");
          para = 1;
          @(negedge clock); para = 0;
        end
        chk_grav("stop");
        chk("stop_gravando", gravando, 0);
      end else if (ev_g[i] >= 0) begin
        @(negedge clock); nota_ativa = 0; m_add(ev_n[i], ev_h[i]);
        @(negedge clock); chk_grav("release");
        wait_ticks(ev_g[i]);
      end
    end
  endtask

  task automatic toca_chk(input bit lp, input int passes);
    int   len, tot;
    ent_t e;
    len = m_ent.size();
    tot = lp ? passes * len : len;
    wait_ticks(1);
    @(negedge clock); loop = lp; toca_inicia = 1;
    @(negedge clock); toca_inicia = 0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < tot; k++) begin
      e = m_ent[k % len];
      chk("play_nota", nota_out, e.nota);
      chk("play_valida", nota_out_valida, (e.nota != PAUSA));
      chk("play_tocando", tocando, 1);
      wait_ticks(e.dur);
      @(negedge clock);
      if (!lp && k == tot - 1) begin
        chk("end_fim", fim_reproducao, 1);
        chk("end_tocando", tocando, 0);
        chk("end_valida", nota_out_valida, 0);
        @(negedge clock);
        chk("end_fim_pulse", fim_reproducao, 0);
      end else begin
        chk("step_fim", fim_reproducao, 0);
        chk("step_hold", nota_out, e.nota);
        repeat (2) @(negedge clock);
      end
    end
    if (lp) begin
      chk("wrap_nota", nota_out, m_ent[0].nota);
      para = 1;
      @(negedge clock); para = 0;
      chk("para_tocando", tocando, 0);
      chk("para_valida", nota_out_valida, 0);
      chk("para_estado", db_estado, 0);
      chk("para_fim", fim_reproducao, 0);
    end
  endtask

  initial begin
    int nev, prev, n, g;
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("rst_nota", nota_out, 0);
    chk("rst_valida", nota_out_valida, 0);
    chk("rst_flags", {gravando, tocando, cheio, fim_reproducao}, 0);
    chk("rst_comp", comprimento, 0);
    chk("rst_estado", db_estado, 0);

    // Note 3 for 2 ticks, rest 1 tick, note 5 for 3 ticks, stop while held.
    ev_n[0] = 3; ev_h[0] = 2; ev_g[0] = 1;
    ev_n[1] = 5; ev_h[1] = 3; ev_g[1] = 0;
    grava_seq(2, 0);
    chk("s1_comp", comprimento, 3);
    toca_chk(0, 1);

    // Short press with no tick, then stop: minimum duration of one tick.
    inicia_grava();
    @(negedge clock); nota_in = 7; nota_ativa = 1;
    repeat (3) @(negedge clock);
    nota_ativa = 0; m_add(7, 0);
    @(negedge clock); para = 1;
    @(negedge clock); para = 0;
    chk("s3_comp", comprimento, 1);
    toca_chk(0, 1);

    // 20-tick hold saturates into a single entry.
    ev_n[0] = 2; ev_h[0] = 20; ev_g[0] = 0;
    grava_seq(1, 1);
    chk("sat_comp", comprimento, 1);
    toca_chk(0, 1);

    // Overflow: 9 alternating note/rest events into 8 entries.
    for (int i = 0; i < 5; i++) begin
      ev_n[i] = i + 1; ev_h[i] = 1; ev_g[i] = 1;
    end
    grava_seq(5, 1);
    chk("ovf_comp", comprimento, 8);
    chk("ovf_cheio", cheio, 1);
    chk("ovf_gravando", gravando, 0);
    toca_chk(1, 2);

    // Randomized recordings replayed once.
    for (int it = 0; it < 4; it++) begin
      nev  = $urandom_range(2, 4);
      prev = -1;
      for (int i = 0; i < nev; i++) begin
        do n = $urandom_range(0, 14); while (n == prev);
        ev_n[i] = n; prev = n;
        ev_h[i] = $urandom_range(1, 3);
        g = $urandom_range(0, 3);
        ev_g[i] = (g == 3) ? -1 : g;
      end
      grava_seq(nev, $urandom_range(0, 1));
      toca_chk(0, 1);
    end

    // Reset in the middle of looped playback, then play with nothing stored.
    wait_ticks(1);
    @(negedge clock); loop = 1; toca_inicia = 1;
    @(negedge clock); toca_inicia = 0;
    wait_ticks(2);
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    chk("mid_rst_nota", nota_out, 0);
    chk("mid_rst_valida", nota_out_valida, 0);
    chk("mid_rst_flags", {gravando, tocando, cheio, fim_reproducao}, 0);
    chk("mid_rst_comp", comprimento, 0);
    chk("mid_rst_estado", db_estado, 0);
    toca_inicia = 1;
    @(negedge clock); toca_inicia = 0;
    chk("empty_fim", fim_reproducao, 1);
    chk("empty_estado", db_estado, 0);
    @(negedge clock);
    chk("empty_fim_pulse", fim_reproducao, 0);
    chk("empty_tocando", tocando, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
